// File: rtl/jt6295_nibble_fetch.sv
// Four-channel ADPCM nibble sequencer: serves one channel per cen slot and keeps each
// channel's one-byte buffer filled through a single shared ROM port.
module jt6295_nibble_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic [3:0]  start,
   input  logic [3:0]  stop,
   input  logic [17:0] start_addr,
   input  logic [17:0] stop_addr,
   input  logic [3:0]  att_in,
   output logic [17:0] rom_addr,
   output logic        rom_cs,
   input  logic [7:0]  rom_data,
   input  logic        rom_ok,
   output logic [3:0]  data,
   output logic        en,
   output logic [3:0]  att,
   output logic [3:0]  busy,
   output logic [3:0]  underrun
);

   typedef enum logic {StIdle, StReq} state_e;

   logic [1:0]  sl_q, sl_d;
   logic [3:0]  playing_q, playing_d;
   logic [3:0]  phase_q, phase_d;
   logic [3:0]  valid_q, valid_d;
   logic [3:0]  underrun_q, underrun_d;
   logic [17:0] addr_q [4];
   logic [17:0] addr_d [4];
   logic [17:0] end_q [4];
   logic [17:0] end_d [4];
   logic [3:0]  att_q [4];
   logic [3:0]  att_d [4];
   logic [7:0]  byte_q [4];
   logic [7:0]  byte_d [4];

   state_e      state_q, state_d;
   logic [1:0]  fch_q, fch_d;
   logic [17:0] rom_addr_q, rom_addr_d;
   logic [3:0]  data_q, data_d;
   logic [3:0]  att_out_q, att_out_d;
   logic        en_q, en_d;

   logic [3:0]  cmd;
   logic [3:0]  need;
   logic        sel_hit;
   logic [1:0]  sel_ch;

   assign cmd  = start | stop;
   // A channel being commanded this clk must not be picked with its stale address.
   assign need = playing_q & ~valid_q & ~cmd;

   // Lowest offset from sl wins, so the channel served next is fetched first.
   always_comb begin
      sel_hit = 1'b0;
      sel_ch  = sl_q;
      for (int k = 3; k >= 0; k--) begin
         if (need[sl_q + 2'(k)]) begin
            sel_hit = 1'b1;
            sel_ch  = sl_q + 2'(k);
         end
      end
   end

   always_comb begin
      sl_d       = sl_q;
      playing_d  = playing_q;
      phase_d    = phase_q;
      valid_d    = valid_q;
      underrun_d = underrun_q;
      addr_d     = addr_q;
      end_d      = end_q;
      att_d      = att_q;
      byte_d     = byte_q;
      state_d    = state_q;
      fch_d      = fch_q;
      rom_addr_d = rom_addr_q;
      data_d     = data_q;
      att_out_d  = att_out_q;
      en_d       = en_q;

      if (cen) begin
         sl_d      = sl_q + 2'd1;
         en_d      = 1'b0;
         data_d    = 4'd0;
         att_out_d = att_q[sl_q];
         if (!cmd[sl_q] && playing_q[sl_q]) begin
            if (valid_q[sl_q]) begin
               en_d = 1'b1;
               if (!phase_q[sl_q]) begin
                  data_d         = byte_q[sl_q][7:4];
                  phase_d[sl_q]  = 1'b1;
               end else begin
                  data_d         = byte_q[sl_q][3:0];
                  phase_d[sl_q]  = 1'b0;
                  valid_d[sl_q]  = 1'b0;
                  addr_d[sl_q]   = addr_q[sl_q] + 18'd1;
                  if (addr_q[sl_q] == end_q[sl_q]) playing_d[sl_q] = 1'b0;
               end
            end else begin
               underrun_d[sl_q] = 1'b1;
            end
         end
      end

      unique case (state_q)
         StIdle: begin
            if (sel_hit) begin
               state_d    = StReq;
               fch_d      = sel_ch;
               rom_addr_d = addr_q[sel_ch];
            end
         end
         StReq: begin
            if (cmd[fch_q]) begin
               state_d = StIdle;
            end else if (rom_ok) begin
               byte_d[fch_q]  = rom_data;
               valid_d[fch_q] = 1'b1;
               state_d        = StIdle;
            end
         end
      endcase

      // Commands come last so they override playback and fetch updates.
      for (int n = 0; n < 4; n++) begin
         if (start[n]) begin
            addr_d[n]     = start_addr;
            end_d[n]      = stop_addr;
            att_d[n]      = att_in;
            phase_d[n]    = 1'b0;
            valid_d[n]    = 1'b0;
            playing_d[n]  = 1'b1;
            underrun_d[n] = 1'b0;
         end else if (stop[n]) begin
            playing_d[n] = 1'b0;
            valid_d[n]   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sl_q       <= '0;
         playing_q  <= '0;
         phase_q    <= '0;
         valid_q    <= '0;
         underrun_q <= '0;
         state_q    <= StIdle;
         fch_q      <= '0;
         rom_addr_q <= '0;
         data_q     <= '0;
         att_out_q  <= '0;
         en_q       <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            addr_q[n] <= '0;
            end_q[n]  <= '0;
            att_q[n]  <= '0;
            byte_q[n] <= '0;
         end
      end else begin
         sl_q       <= sl_d;
         playing_q  <= playing_d;
         phase_q    <= phase_d;
         valid_q    <= valid_d;
         underrun_q <= underrun_d;
         state_q    <= state_d;
         fch_q      <= fch_d;
         rom_addr_q <= rom_addr_d;
         data_q     <= data_d;
         att_out_q  <= att_out_d;
         en_q       <= en_d;
         for (int n = 0; n < 4; n++) begin
            addr_q[n] <= addr_d[n];
            end_q[n]  <= end_d[n];
            att_q[n]  <= att_d[n];
            byte_q[n] <= byte_d[n];
         end
      end
   end

   assign rom_addr = rom_addr_q;
   assign rom_cs   = (state_q == StReq);
   assign data     = data_q;
   assign en       = en_q;
   assign att      = att_out_q;
   assign busy     = playing_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_jt6295_nibble_fetch.sv
// Directed bench for jt6295_nibble_fetch: latency-programmable ROM model, slot logger and
// hand-computed nibble sequences.
module tb_jt6295_nibble_fetch;

   logic        clk, rst, cen;
   logic [3:0]  start, stop, att_in;
   logic [17:0] start_addr, stop_addr, rom_addr;
   logic        rom_cs, rom_ok, en;
   logic [7:0]  rom_data;
   logic [3:0]  data, att, busy, underrun;

   jt6295_nibble_fetch dut (
      .clk(clk), .rst(rst), .cen(cen), .start(start), .stop(stop),
      .start_addr(start_addr), .stop_addr(stop_addr), .att_in(att_in),
      .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
      .data(data), .en(en), .att(att), .busy(busy), .underrun(underrun)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ROM model: rom_ok after rom_lat clks of continuous rom_cs.
   int rom_lat = 1;
   int rom_cnt = 0;
   always @(posedge clk) rom_cnt <= rom_cs ? rom_cnt + 1 : 0;
   assign rom_ok = rom_cs && (rom_cnt >= rom_lat);

   function automatic logic [7:0] rom_byte(input logic [17:0] a);
      case (a)
         18'h00100: return 8'hA5;
         18'h00101: return 8'h3C;
         18'h01000: return 8'h12;
         18'h01001: return 8'h34;
         18'h02000: return 8'h56;
         18'h02001: return 8'h78;
         18'h03000: return 8'h9A;
         18'h03001: return 8'hBC;
         18'h04000: return 8'hDE;
         18'h04001: return 8'hF0;
         18'h3FFFF: return 8'hC3;
         18'h00000: return 8'h7E;
         default:   return 8'hEE;
      endcase
   endfunction
   always_comb rom_data = rom_byte(rom_addr);

   logic [17:0] fetched[$];
   always @(posedge clk) if (!rst && rom_cs && rom_ok) fetched.push_back(rom_addr);

   // cen generator
   logic cen_run = 1'b0;
   int   cen_cnt = 0;
   initial begin
      cen = 1'b0;
      forever begin
         @(negedge clk);
         if (cen_run) begin
            if (cen_cnt == 7) begin cen = 1'b1; cen_cnt = 0; end
            else begin cen = 1'b0; cen_cnt++; end
         end else begin
            cen = 1'b0;
            cen_cnt = 0;
         end
      end
   end

   typedef struct {
      int         idx;
      logic       en;
      logic [3:0] data;
      logic [3:0] att;
      logic [3:0] busy;
      logic [3:0] underrun;
   } slot_t;
   slot_t log_q[$];
   slot_t ent;
   always @(posedge clk) begin
      if (cen && !rst) begin
         #1;
         ent.idx = log_q.size(); ent.en = en; ent.data = data; ent.att = att;
         ent.busy = busy; ent.underrun = underrun;
         log_q.push_back(ent);
      end
   end

   // Index into log_q of the k-th en=1 slot of channel ch (ch<0: any channel), or -1.
   function automatic int en_idx(input int ch, input int k);
      int c = 0;
      for (int i = 0; i < log_q.size(); i++) begin
         if (log_q[i].en && (ch < 0 || (i % 4) == ch)) begin
            if (c == k) return i;
            c++;
         end
      end
      return -1;
   endfunction

   function automatic logic [3:0] nib(input int ch, input int k);
      int j = en_idx(ch, k);
      return (j >= 0) ? log_q[j].data : 4'hx;
   endfunction

   function automatic logic [31:0] fget(input int i);
      return (i < fetched.size()) ? 32'(fetched[i]) : 32'hDEAD_BEEF;
   endfunction

   task automatic do_reset();
      cen_run = 1'b0; start = '0; stop = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      log_q.delete();
      fetched.delete();
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] st, input logic [3:0] sp, input logic [17:0] sa,
                        input logic [17:0] ea, input logic [3:0] at);
      @(negedge clk);
      start = st; stop = sp; start_addr = sa; stop_addr = ea; att_in = at;
      @(posedge clk);
      #1;
      start = '0; stop = '0;
   endtask

   task automatic wait_log(input int n);
      int t = 0;
      while (log_q.size() < n && t < 5000) begin @(posedge clk); t++; end
   endtask

   task automatic wait_idle(input int ch, input int budget, input string tag);
      int t = 0;
      while (busy[ch] && t < budget) begin @(posedge clk); #1; t++; end
      check(tag, 32'(busy[ch]), 0);
   endtask

   task automatic wait_cs(input int budget, input string tag);
      int t = 0;
      while (!rom_cs && t < budget) begin @(posedge clk); #1; t++; end
      check(tag, 32'(rom_cs), 1);
   endtask

   logic [3:0] e35[4] = '{4'hA, 4'h5, 4'h3, 4'hC};
   logic [3:0] e36[16] = '{4'h1, 4'h5, 4'h9, 4'hD, 4'h2, 4'h6, 4'hA, 4'hE,
                           4'h3, 4'h7, 4'hB, 4'hF, 4'h4, 4'h8, 4'hC, 4'h0};
   logic [3:0] e39[4] = '{4'hC, 4'h3, 4'h7, 4'hE};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int misses;
      int j;
      logic seen_cs;
      start = '0; stop = '0; start_addr = '0; stop_addr = '0; att_in = '0;

      // Reset state
      rst = 1'b1;
      #12;
      check("rst_rom_cs", 32'(rom_cs), 0);
      check("rst_outs", {rom_addr, data, en, att, busy, underrun}, 0);
      do_reset();

      // Basic two-byte phrase on channel 0
      rom_lat = 1;
      pulse(4'b0001, 4'b0000, 18'h00100, 18'h00101, 4'h5);
      check("t35_busy_set", 32'(busy), 32'h1);
      repeat (10) @(posedge clk);
      cen_run = 1'b1;
      wait_log(17);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t35_en%0d", k), 32'(log_q[4*k].en), 1);
         check($sformatf("t35_nib%0d", k), 32'(log_q[4*k].data), 32'(e35[k]));
      end
      check("t35_att", 32'(log_q[0].att), 32'h5);
      check("t35_ch1_idle", {log_q[1].en, log_q[1].data}, 0);
      check("t35_busy_before_last", 32'(log_q[8].busy[0]), 1);
      check("t35_busy_at_last", 32'(log_q[12].busy[0]), 0);
      check("t35_after_end", 32'(log_q[16].en), 0);
      check("t35_underrun", 32'(underrun), 0);

      // All four channels interleaved
      do_reset();
      rom_lat = 2;
      for (int n = 0; n < 4; n++)
         pulse(4'(1 << n), 4'b0000, 18'h01000 * 18'(n + 1), 18'h01000 * 18'(n + 1) + 18'd1,
               4'(n + 3));
      repeat (40) @(posedge clk);
      cen_run = 1'b1;
      wait_log(20);
      for (int k = 0; k < 16; k++) begin
         j = en_idx(-1, k);
         check($sformatf("t36_nib%0d", k), 32'(nib(-1, k)), 32'(e36[k]));
         check($sformatf("t36_att%0d", k), (j >= 0) ? 32'(log_q[j].att) : 32'hFF, k % 4 + 3);
      end
      check("t36_en_count_end", 32'(en_idx(-1, 16)), 32'hFFFF_FFFF);
      check("t36_underrun", 32'(underrun), 0);
      check("t36_busy_end", 32'(busy), 0);

      // Slow ROM: missed slots, no address skip
      do_reset();
      rom_lat = 40;
      cen_run = 1'b1;
      pulse(4'b0001, 4'b0000, 18'h00100, 18'h00101, 4'h0);
      wait_idle(0, 3000, "t37_timeout");
      repeat (40) @(posedge clk);
      misses = 0;
      for (int i = 0; i < log_q.size(); i += 4)
         if (!log_q[i].en && log_q[i].busy[0]) misses++;
      check("t37_missed", 32'(misses > 0), 1);
      for (int k = 0; k < 4; k++)
         check($sformatf("t37_nib%0d", k), 32'(nib(0, k)), 32'(e35[k]));
      check("t37_underrun", 32'(underrun), 32'h1);
      check("t37_fetch_cnt", fetched.size(), 2);
      check("t37_fetch0", fget(0), 32'h100);
      check("t37_fetch1", fget(1), 32'h101);

      // start/stop coincidence and stop during a pending fetch
      do_reset();
      rom_lat = 20;
      pulse(4'b0010, 4'b0010, 18'h02000, 18'h02001, 4'h2);
      check("t38_start_prio", 32'(busy), 32'h2);
      wait_cs(10, "t38_cs_timeout");
      check("t38_rom_addr", 32'(rom_addr), 32'h2000);
      pulse(4'b0000, 4'b0010, 18'h0, 18'h0, 4'h0);
      check("t38_cs_abort", 32'(rom_cs), 0);
      check("t38_busy_clr", 32'(busy), 0);
      repeat (5) @(posedge clk);
      #1;
      check("t38_cs_stays_low", 32'(rom_cs), 0);

      // Address wrap 3FFFF -> 00000
      do_reset();
      rom_lat = 1;
      pulse(4'b0100, 4'b0000, 18'h3FFFF, 18'h00000, 4'h1);
      repeat (10) @(posedge clk);
      cen_run = 1'b1;
      wait_idle(2, 1000, "t39_timeout");
      repeat (20) @(posedge clk);
      #1;
      check("t39_fetch_cnt", fetched.size(), 2);
      check("t39_fetch0", fget(0), 32'h3FFFF);
      check("t39_fetch1", fget(1), 32'h0);
      check("t39_idle_cs", 32'(rom_cs), 0);
      for (int k = 0; k < 4; k++)
         check($sformatf("t39_nib%0d", k), 32'(nib(2, k)), 32'(e39[k]));

      // Reset in the middle of a fetch
      do_reset();
      rom_lat = 10;
      pulse(4'b0001, 4'b0000, 18'h00100, 18'h00101, 4'h7);
      wait_cs(10, "t40_cs_timeout");
      @(negedge clk) rst = 1'b1;
      #1;
      check("t40_rst_cs", 32'(rom_cs), 0);
      check("t40_rst_addr", 32'(rom_addr), 0);
      check("t40_rst_busy", 32'(busy), 0);
      check("t40_rst_outs", {data, en, att, underrun}, 0);
      repeat (2) @(posedge clk);
      log_q.delete();
      fetched.delete();
      @(negedge clk) rst = 1'b0;
      cen_run = 1'b1;
      seen_cs = 1'b0;
      repeat (6) begin @(posedge clk); #1; seen_cs |= rom_cs; end
      check("t40_no_cs_after", 32'(seen_cs), 0);
      wait_log(1);
      check("t40_first_slot", {log_q[0].en, log_q[0].data}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
